udp_disp_ctrl: RTL and testbench

Parametrised LED / 7-segment display controller fed by the UDP receive application stream. It assembles each incoming packet into a shadow buffer and commits it atomically only when a complete, long-enough packet has arrived. It then drives either raw LED patterns or a multiplexed N-digit display with BCD or hex decoding, decimal points and anti-ghosting blanking. It sits after the UDP stack's application RX port, in the udp_rx_clk domain, and drives board pins directly.

---
 rtl/udp_disp_pkg.sv | 21 ++
 rtl/udp_disp_ctrl_seg7_decode.sv | 20 ++
 rtl/udp_disp_ctrl.sv | 148 ++++++++++++++
 tb/tb_udp_disp_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_disp_pkg.sv
// Shared constants for the UDP-fed LED / 7-segment display controller:
// display modes, minimum packet length and active-low segment codes.
package udp_disp_pkg;

   localparam logic [3:0] MODE_BCD   = 4'h0;
   localparam logic [3:0] MODE_HEX   = 4'h1;
   localparam logic [3:0] MODE_BLANK = 4'hE;
   localparam logic [3:0] MODE_LED   = 4'hF;

   // {dp,g..a}, active-low; bit 7 is always 1 here so DP starts off.
   localparam logic [7:0] SEG_CODE [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   // Mode byte + digit nibble pairs + decimal-point mask bytes.
   function automatic int req_len(input int num_digits);
      return 1 + num_digits / 2 + num_digits / 8;
   endfunction

endpackage

// File: rtl/udp_disp_ctrl_seg7_decode.sv
// Combinational nibble to active-low 7-segment decoder with DP control.
// In BCD operation (hex_en low) nibbles A-F show as blank segments.
module seg7_decode
   import udp_disp_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       hex_en,
   input  logic       dp,
   output logic [7:0] seg
);

   always_comb begin
      seg = SEG_CODE[nibble];
      if (!hex_en && (nibble > 4'd9)) begin
         seg = 8'hFF;
      end
      seg[7] = ~dp;
   end

endmodule

// File: rtl/udp_disp_ctrl.sv
// Display controller on the UDP application RX stream: packets are assembled
// into a shadow buffer, committed atomically, then shown as LEDs or scanned digits.
module udp_disp_ctrl
   import udp_disp_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int SCAN_DIV   = 65536,
   parameter int BLANK_CYC  = 256
) (
   input  logic                  udp_rx_clk,
   input  logic                  reset,
   input  logic                  app_rx_data_valid,
   input  logic [7:0]            app_rx_data,
   input  logic [15:0]           app_rx_data_length,
   output logic [3:0]            led_data_1,
   output logic [NUM_DIGITS-1:0] dled,
   output logic [7:0]            tub,
   output logic                  pkt_ok,
   output logic                  pkt_err
);

   localparam int REQ_LEN = req_len(NUM_DIGITS);
   localparam int MB      = NUM_DIGITS / 8;
   localparam int SW      = $clog2(NUM_DIGITS);
   localparam int DW      = $clog2(SCAN_DIV);

   logic [15:0]                 byte_cnt, len_q, len_cur;
   logic                        last_beat, commit, drop;
   logic [REQ_LEN-1:0][7:0]     shadow, shadow_nxt, active;
   logic [DW-1:0]               div_cnt;
   logic [SW-1:0]               scan_idx, dig_idx;
   logic [4*NUM_DIGITS-1:0]     digits;
   logic [NUM_DIGITS-1:0]       dp_mask, led_dled, dled_nxt;
   logic [3:0]                  nib, mode;
   logic                        dp_sel, hex_en;
   logic [7:0]                  seg, tub_nxt;

   // The length field is only trusted on byte 0; later beats use the latched copy.
   always_comb begin
      len_cur   = (byte_cnt == 16'd0) ? app_rx_data_length : len_q;
      last_beat = app_rx_data_valid &&
                  ((len_cur == 16'd0) || (byte_cnt == len_cur - 16'd1));
      commit    = last_beat && (len_cur >= 16'(REQ_LEN));
      drop      = last_beat && !commit;
      shadow_nxt = shadow;
      if (app_rx_data_valid) begin
         for (int i = 0; i < REQ_LEN; i++) begin
            if (byte_cnt == 16'(i)) shadow_nxt[i] = app_rx_data;
         end
      end
   end

   always_ff @(posedge udp_rx_clk) begin
      if (reset) begin
         byte_cnt  <= 16'd0;
         len_q     <= 16'd0;
         shadow    <= '0;
         active    <= '0;
         active[0] <= {4'h0, MODE_BLANK};
         pkt_ok    <= 1'b0;
         pkt_err   <= 1'b0;
      end else begin
         pkt_ok  <= commit;
         pkt_err <= drop;
         if (app_rx_data_valid) begin
            byte_cnt <= last_beat ? 16'd0 : byte_cnt + 16'd1;
            if (byte_cnt == 16'd0) len_q <= app_rx_data_length;
            shadow <= shadow_nxt;
         end
         if (commit) active <= shadow_nxt;
      end
   end

   always_ff @(posedge udp_rx_clk) begin
      if (reset) begin
         div_cnt  <= '0;
         scan_idx <= '0;
      end else if (div_cnt == DW'(SCAN_DIV - 1)) begin
         div_cnt  <= '0;
         scan_idx <= (scan_idx == SW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // Flatten the active buffer so digit k sits at nibble k and mask bit k at bit k.
   always_comb begin
      digits   = '0;
      dp_mask  = '0;
      led_dled = '0;
      for (int i = 0; i < NUM_DIGITS / 2; i++) begin
         digits[4*NUM_DIGITS-1-8*i -: 8] = active[1+i];
      end
      for (int i = 0; i < MB; i++) begin
         dp_mask[NUM_DIGITS-1-8*i -: 8]  = active[1+NUM_DIGITS/2+i];
         led_dled[NUM_DIGITS-1-8*i -: 8] = active[1+i];
      end
      mode    = active[0][3:0];
      hex_en  = (mode == MODE_HEX);
      dig_idx = SW'(NUM_DIGITS - 1) - scan_idx;
      nib     = 4'h0;
      dp_sel  = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (dig_idx == SW'(k)) begin
            nib    = digits[4*k +: 4];
            dp_sel = dp_mask[k];
         end
      end
   end

   seg7_decode u_seg7_decode (
      .nibble (nib),
      .hex_en (hex_en),
      .dp     (dp_sel),
      .seg    (seg)
   );

   always_comb begin
      tub_nxt  = 8'hFF;
      dled_nxt = '1;
      case (mode)
         MODE_BCD, MODE_HEX: begin
            if (div_cnt >= DW'(BLANK_CYC)) begin
               tub_nxt  = seg;
               dled_nxt = ~(NUM_DIGITS'(1) << scan_idx);
            end
         end
         MODE_LED: begin
            dled_nxt = led_dled;
            tub_nxt  = active[1+MB];
         end
         default: ;
      endcase
   end

   always_ff @(posedge udp_rx_clk) begin
      if (reset) begin
         tub        <= 8'hFF;
         dled       <= '1;
         led_data_1 <= 4'h0;
      end else begin
         tub        <= tub_nxt;
         dled       <= dled_nxt;
         led_data_1 <= active[0][7:4];
      end
   end

endmodule

// File: tb/tb_udp_disp_ctrl.sv
// Self-checking bench for udp_disp_ctrl: commit/drop pulses are scoreboarded,
// display outputs are compared against hand-derived patterns at known scan slots.
module tb_udp_disp_ctrl;

   localparam int ND = 8;
   localparam int SD = 16;
   localparam int BC = 4;

   logic          udp_rx_clk = 1'b0;
   logic          reset = 1'b1;
   logic          app_rx_data_valid = 1'b0;
   logic [7:0]    app_rx_data = 8'h00;
   logic [15:0]   app_rx_data_length = 16'h0000;
   logic [3:0]    led_data_1;
   logic [ND-1:0] dled;
   logic [7:0]    tub;
   logic          pkt_ok, pkt_err;

   always #5 udp_rx_clk = ~udp_rx_clk;

   udp_disp_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
      .udp_rx_clk         (udp_rx_clk),
      .reset              (reset),
      .app_rx_data_valid  (app_rx_data_valid),
      .app_rx_data        (app_rx_data),
      .app_rx_data_length (app_rx_data_length),
      .led_data_1         (led_data_1),
      .dled               (dled),
      .tub                (tub),
      .pkt_ok             (pkt_ok),
      .pkt_err            (pkt_err)
   );

   typedef struct {
      bit ok;
      int due;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   logic [7:0] pkt_buf [16];

   // Independent scan position: od/os describe the slot the outputs show now.
   int div_m = 0, s_m = 0, odiv = 0, os = 0;
   always @(posedge udp_rx_clk) begin
      cyc  <= cyc + 1;
      odiv <= div_m;
      os   <= s_m;
      if (reset) begin
         div_m <= 0;
         s_m   <= 0;
      end else if (div_m == SD - 1) begin
         div_m <= 0;
         s_m   <= (s_m == ND - 1) ? 0 : s_m + 1;
      end else begin
         div_m <= div_m + 1;
      end
   end

   always @(negedge udp_rx_clk) begin
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
         checks++;
         errors++;
         $display("FAIL pulse_missing: no pulse seen, required %s at cycle %0d",
                  exp_q[0].ok ? "pkt_ok" : "pkt_err", exp_q[0].due);
         void'(exp_q.pop_front());
      end
      if (pkt_ok || pkt_err) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pulse_unexpected: ok=%0b err=%0b at cycle %0d, required no pulse",
                     pkt_ok, pkt_err, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            if (pkt_ok !== mon_e.ok || pkt_err !== !mon_e.ok || cyc != mon_e.due) begin
               errors++;
               $display("FAIL pulse_kind: ok=%0b err=%0b at cycle %0d, required %s at cycle %0d",
                        pkt_ok, pkt_err, cyc, mon_e.ok ? "pkt_ok" : "pkt_err", mon_e.due);
            end
         end
      end
   end

   task automatic load(input logic [63:0] v, input int n);
      for (int i = 0; i < n; i++) pkt_buf[i] = v[8*(n-1-i) +: 8];
   endtask

   task automatic send_pkt(input int n, input logic [15:0] len, input bit keep);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         @(posedge udp_rx_clk);
         #1;
         app_rx_data_valid  = 1'b1;
         app_rx_data        = pkt_buf[i];
         app_rx_data_length = (i == 0) ? len : 16'hDEAD;
         if (len == 16'd0 || i == int'(len) - 1) begin
            e.ok  = (len >= 16'd6);
            e.due = cyc + 1;
            exp_q.push_back(e);
         end
      end
      if (!keep) begin
         @(posedge udp_rx_clk);
         #1;
         app_rx_data_valid = 1'b0;
      end
   endtask

   task automatic wait_slot(input int slot, input int d, output bit found);
      found = 1'b0;
      for (int i = 0; i < 2 * ND * SD + 8; i++) begin
         @(negedge udp_rx_clk);
         if (os == slot && odiv == d) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int bad;
      bad = 0;
      repeat (3) @(posedge udp_rx_clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 3 * ND * SD; i++) begin
         @(negedge udp_rx_clk);
         if (tub !== 8'hFF || dled !== 8'hFF || led_data_1 !== 4'h0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL reset_idle: %0d bad cycles, last tub=%h dled=%h led=%h, required FF FF 0",
                  bad, tub, dled, led_data_1);
      end
   endtask

   task automatic test_led();
      load(64'h5FA53C000000, 6);
      send_pkt(6, 16'd6, 1'b0);
      @(negedge udp_rx_clk);
      checks++;
      if (tub !== 8'hFF || dled !== 8'hFF) begin
         errors++;
         $display("FAIL led_latency: tub=%h dled=%h one cycle after commit, required FF FF", tub, dled);
      end
      @(negedge udp_rx_clk);
      checks++;
      if (dled !== 8'hA5 || tub !== 8'h3C || led_data_1 !== 4'h5) begin
         errors++;
         $display("FAIL led_mode: dled=%h tub=%h led=%h, required A5 3C 5", dled, tub, led_data_1);
      end
   endtask

   task automatic test_short();
      load(64'h7F1122, 3);
      send_pkt(3, 16'd3, 1'b0);
      repeat (3) @(negedge udp_rx_clk);
      checks++;
      if (dled !== 8'hA5 || tub !== 8'h3C || led_data_1 !== 4'h5) begin
         errors++;
         $display("FAIL short_unchanged: dled=%h tub=%h led=%h, required A5 3C 5", dled, tub, led_data_1);
      end
      load(64'h7F, 1);
      send_pkt(1, 16'd0, 1'b0);
      repeat (3) @(negedge udp_rx_clk);
      checks++;
      if (dled !== 8'hA5 || tub !== 8'h3C) begin
         errors++;
         $display("FAIL zero_len_unchanged: dled=%h tub=%h, required A5 3C", dled, tub);
      end
      load(64'h3F5AC3000000, 6);
      send_pkt(6, 16'd6, 1'b0);
      repeat (2) @(negedge udp_rx_clk);
      checks++;
      if (dled !== 8'h5A || tub !== 8'hC3 || led_data_1 !== 4'h3) begin
         errors++;
         $display("FAIL after_short: dled=%h tub=%h led=%h, required 5A C3 3", dled, tub, led_data_1);
      end
   endtask

   task automatic test_long();
      load(64'h9F66990000007711, 8);
      send_pkt(8, 16'd8, 1'b0);
      repeat (2) @(negedge udp_rx_clk);
      checks++;
      if (dled !== 8'h66 || tub !== 8'h99 || led_data_1 !== 4'h9) begin
         errors++;
         $display("FAIL long_pkt: dled=%h tub=%h led=%h, required 66 99 9", dled, tub, led_data_1);
      end
   endtask

   task automatic test_bcd();
      bit found;
      int bad;
      load(64'h001234567881, 6);
      send_pkt(6, 16'd6, 1'b0);
      @(posedge udp_rx_clk);
      wait_slot(0, BC, found);
      checks++;
      if (!found || dled !== 8'hFE || tub !== 8'h79) begin
         errors++;
         $display("FAIL bcd_slot0: found=%0b dled=%h tub=%h, required FE 79", found, dled, tub);
      end
      wait_slot(7, BC + 5, found);
      checks++;
      if (!found || dled !== 8'h7F || tub !== 8'h00) begin
         errors++;
         $display("FAIL bcd_slot7: found=%0b dled=%h tub=%h, required 7F 00", found, dled, tub);
      end
      bad = 0;
      for (int i = 0; i < ND * SD; i++) begin
         @(negedge udp_rx_clk);
         if (odiv < BC) begin
            if (dled !== 8'hFF || tub !== 8'hFF) bad++;
         end else if (dled !== ~(8'h01 << os)) begin
            bad++;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL bcd_blanking: %0d bad cycles, required all-off for first %0d cycles of each slot",
                  bad, BC);
      end
   endtask

   task automatic test_hex_bcd();
      bit found;
      load(64'h01A000000000, 6);
      send_pkt(6, 16'd6, 1'b0);
      @(posedge udp_rx_clk);
      wait_slot(0, BC, found);
      checks++;
      if (!found || dled !== 8'hFE || tub !== 8'h88) begin
         errors++;
         $display("FAIL hex_A: found=%0b dled=%h tub=%h, required FE 88", found, dled, tub);
      end
      wait_slot(1, BC + 3, found);
      checks++;
      if (!found || dled !== 8'hFD || tub !== 8'hC0) begin
         errors++;
         $display("FAIL hex_0: found=%0b dled=%h tub=%h, required FD C0", found, dled, tub);
      end
      load(64'h00A000000000, 6);
      send_pkt(6, 16'd6, 1'b0);
      @(posedge udp_rx_clk);
      wait_slot(0, BC + 2, found);
      checks++;
      if (!found || tub !== 8'hFF) begin
         errors++;
         $display("FAIL bcd_A_blank: found=%0b tub=%h, required FF", found, tub);
      end
   endtask

   task automatic test_back_to_back();
      load(64'h1F8118000000, 6);
      send_pkt(6, 16'd6, 1'b1);
      load(64'h4F2442000000, 6);
      send_pkt(6, 16'd6, 1'b0);
      repeat (2) @(negedge udp_rx_clk);
      checks++;
      if (dled !== 8'h24 || tub !== 8'h42 || led_data_1 !== 4'h4) begin
         errors++;
         $display("FAIL back_to_back: dled=%h tub=%h led=%h, required 24 42 4", dled, tub, led_data_1);
      end
   endtask

   task automatic test_reset_mid();
      load(64'h7F11, 2);
      send_pkt(2, 16'd6, 1'b0);
      @(posedge udp_rx_clk);
      #1 reset = 1'b1;
      @(posedge udp_rx_clk);
      #1 reset = 1'b0;
      @(negedge udp_rx_clk);
      checks++;
      if (tub !== 8'hFF || dled !== 8'hFF || led_data_1 !== 4'h0) begin
         errors++;
         $display("FAIL mid_reset_state: tub=%h dled=%h led=%h, required FF FF 0", tub, dled, led_data_1);
      end
      load(64'h2FC35A000000, 6);
      send_pkt(6, 16'd6, 1'b0);
      repeat (2) @(negedge udp_rx_clk);
      checks++;
      if (dled !== 8'hC3 || tub !== 8'h5A || led_data_1 !== 4'h2) begin
         errors++;
         $display("FAIL mid_reset_realign: dled=%h tub=%h led=%h, required C3 5A 2", dled, tub, led_data_1);
      end
   endtask

   initial begin
      test_reset();
      test_led();
      test_short();
      test_long();
      test_bcd();
      test_hex_bcd();
      test_back_to_back();
      test_reset_mid();
      repeat (4) @(negedge udp_rx_clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d pulses outstanding, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
